// File: rtl/hilo_seq.sv
// hilo_seq: multi-cycle HI/LO unit (shift-add multiply, restoring divide, mthi/mtlo, mul)
module hilo_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [1:0]  multiply,
  input  logic [1:0]  divide,
  input  logic [1:0]  HI_sel,
  input  logic [1:0]  LO_sel,
  input  logic [1:0]  MultoRF,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mul_lo,
  output logic        mul_valid,
  output logic        busy,
  output logic        stall,
  output logic        dz
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, MRET = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, prod;
  logic [31:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d, mul_lo_q, mul_lo_d, rs_abs, rt_abs;
  logic        dz_q, dz_d, is_div_q, is_div_d, is_mul_q, is_mul_d, zero_q, zero_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, sg, start_div, zero_c;
  logic [32:0] msum, dsub;
  assign busy      = state_q == CALC || state_q == FIX;
  assign mul_valid = state_q == MRET;
  assign stall     = issue && busy && (MultoRF == 2'd2 || MultoRF == 2'd3 || multiply[1] ||
                     divide[1] || HI_sel == 2'b00 || LO_sel == 2'b00);
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign mul_lo = mul_lo_q;
  assign dz     = dz_q;
  always_comb begin
    sg        = multiply[1] ? multiply[0] : divide[0];
    start_div = !multiply[1];
    zero_c    = start_div && rt_val == 32'd0;
    rs_abs    = (sg && rs_val[31]) ? -rs_val : rs_val;
    rt_abs    = (sg && rt_val[31]) ? -rt_val : rt_val;
    msum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    dsub      = acc_q[63:31] - {1'b0, a_q};
    prod      = neg_q ? -acc_q : acc_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_lo_d  = mul_lo_q;
    dz_d      = dz_q;
    is_div_d  = is_div_q;
    is_mul_d  = is_mul_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    if (state_q == IDLE && issue) begin
      if (multiply[1] || divide[1]) begin
        state_d  = zero_c ? FIX : CALC;
        cnt_d    = 5'd0;
        a_d      = rt_abs;
        acc_d    = {zero_c ? rs_val : 32'd0, rs_abs};
        is_div_d = start_div;
        is_mul_d = multiply[1] && HI_sel == 2'b11;
        zero_d   = zero_c;
        neg_d    = sg && (rs_val[31] ^ rt_val[31]);
        rneg_d   = sg && rs_val[31];
        dz_d     = start_div ? 1'b0 : dz_q;
      end else begin
        hi_d = HI_sel == 2'b00 ? rs_val : hi_q;
        lo_d = LO_sel == 2'b00 ? rs_val : lo_q;
      end
    end else if (state_q == CALC) begin
      cnt_d   = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? FIX : CALC;
      acc_d   = is_div_q ? {dsub[32] ? acc_q[62:31] : dsub[31:0], acc_q[30:0], ~dsub[32]}
                         : {msum, acc_q[31:1]};
    end else if (state_q == FIX) begin
      state_d = is_mul_q ? MRET : IDLE;
      if (zero_q) begin
        hi_d = acc_q[63:32];
        lo_d = 32'hFFFF_FFFF;
        dz_d = 1'b1;
      end else if (is_div_q) begin
        hi_d = rneg_q ? -acc_q[63:32] : acc_q[63:32];
        lo_d = neg_q ? -acc_q[31:0] : acc_q[31:0];
      end else if (is_mul_q) begin
        mul_lo_d = prod[31:0];
      end else begin
        hi_d = prod[63:32];
        lo_d = prod[31:0];
      end
    end else if (state_q == MRET) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mul_lo_q <= '0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
      is_mul_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mul_lo_q <= mul_lo_d;
      dz_q     <= dz_d;
      is_div_q <= is_div_d;
      is_mul_q <= is_mul_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end
endmodule

// File: doc/hilo_seq.md
HILO_SEQ -- requirements
Module: hilo_seq

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high. Ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-002 SHALL have: issue  in  1  decoded instruction present this cycle (held while stall=1).
REQ-003 SHALL have: multiply  in  2  [1]=enable, [0]=signed; divide  in  2  same encoding.
REQ-004 SHALL have: HI_sel, LO_sel  in  2 each  00=move-from-rs, 01=mult result, 10=div result, 11=no write; MultoRF  in  2  2=mfhi, 3=mflo.
REQ-005 SHALL have: rs_val, rt_val  in  32 each  operands.
REQ-006 SHALL have outputs: hi_out, lo_out  32 each  HI/LO registers; mul_lo  32  low product for mul; mul_valid  1; busy  1; stall  1 (combinational); dz  1  last divide had divisor 0.

Function
REQ-007 SHALL have states IDLE, CALC, FIX and MRET; busy=1 in CALC and FIX.
REQ-008 SHALL accept an op only in IDLE with issue=1 and stall=0. Issue in CALC, FIX or MRET SHALL be ignored.
REQ-009 mult/multu (multiply[1]=1, HI_sel=LO_sel=01): accept at edge E0, latch |rs|,|rt| (or raw when unsigned), CALC 32 iterations over edges E1..E32, FIX, write HI/LO at E33, then IDLE.
REQ-010 mul (multiply[1]=1, HI_sel=11): same timing as mult; at E33 SHALL load mul_lo with product[31:0], leave HI/LO unchanged, enter MRET.
REQ-011 In MRET (one cycle): mul_valid=1, stall=0; next edge -> IDLE. mul_valid SHALL be 0 in all other states.
REQ-012 div/divu (divide[1]=1, HI_sel=LO_sel=10): restoring radix-2, same 32+1 cycle timing; LO=quotient, HI=remainder; dz cleared at acceptance.
REQ-013 Signed mult: 64-bit product negated in FIX when sign(rs)^sign(rt). Signed div: quotient negated when signs differ, remainder takes sign(rs). 0x80000000/-1 SHALL give LO=0x80000000, HI=0.
REQ-014 Divide with rt_val=0: skip CALC, go E0->FIX, at E1 write LO=0xFFFFFFFF, HI=rs_val (no sign fix), set dz=1.
REQ-015 mthi/mtlo (HI_sel or LO_sel=00, multiply[1]=divide[1]=0) in IDLE: write rs_val into HI resp. LO at the accepting edge; no state change.
REQ-016 stall = issue AND (state in {CALC,FIX}) AND (MultoRF in {2,3} OR multiply[1] OR divide[1] OR HI_sel=00 OR LO_sel=00). stall SHALL also be 1 for the issuing mul while in CALC/FIX.
REQ-017 Other instructions SHALL never stall; a mult/div in progress SHALL NOT be disturbed by them.
REQ-018 hi_out/lo_out SHALL change only at the write edges of REQ-009, REQ-012, REQ-014 and REQ-015.
REQ-019 Iteration counter SHALL be 5 bits and wrap 31->0 on the transition to FIX.

Reset
REQ-020 rst=1 SHALL immediately force state=IDLE and hi_out=lo_out=mul_lo=0, busy=mul_valid=dz=0, counter=0, including when asserted mid-CALC; the aborted op SHALL write nothing.
REQ-021 After rst deasserts, the first accepted op SHALL behave per REQ-009..015.

Verification
REQ-022 mult rs=0xFFFFFFFF, rt=2 -> busy=1 for exactly 33 cycles; at E33 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-023 multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-024 div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu rs=5, rt=0 -> busy 1 cycle, LO=0xFFFFFFFF, HI=5, dz=1.
REQ-025 mfhi issued 5 cycles after a mult acceptance -> stall=1 until IDLE, then HI equals the product high word; an add issued during CALC -> stall=0.
REQ-026 mul rs=3, rt=0xFFFFFFFC -> stall=1 through FIX; MRET cycle shows mul_valid=1, mul_lo=0xFFFFFFF4, stall=0; HI/LO unchanged; no re-accept.
REQ-027 rst pulsed at E10 of a div -> outputs zero immediately; no later HI/LO write; next mtlo rs=0x1234 -> lo_out=0x1234.
